upstream_aligner: RTL and testbench
===================================

# upstream_aligner

The upstream aligner sits between the source-side read bus and `upstream_req_n_data`. It is started by `busif_start` together with `src_addr` and `byte_length`. It fetches the byte-addressed source buffer as qword-aligned 64-bit reads and re-packs the bytes so that output byte 0 is the byte at `src_addr`. It then streams exactly ceil(`byte_length`/8) qwords on `aligner_data`/`aligner_data_en`. Its data output has no backpressure: the consumer reserves room before starting.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum number of acknowledged read requests whose data has not yet returned (range 1..15).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `busif_start` in 1: level. High for the whole transfer. A low level aborts the transfer.
- `src_addr` in 32: source byte address. Stable while `busif_start` is high.
- `byte_length` in 16: transfer length in bytes. Stable while `busif_start` is high.
- `rd_req` out 1: read request. Held high until acknowledged.
- `rd_addr` out 32: qword-aligned read address (bits [2:0] are always 0).
- `rd_ack` in 1: request accepted when `rd_req & rd_ack` at a rising edge.
- `rd_data` in 64: read data, returned in request order. Little-endian (byte 0 is in bits [7:0]).
- `rd_data_valid` in 1: one returned qword per cycle when high. Latency after ack is arbitrary, ≥1 cycle.
- `aligner_data` out 64: aligned qword.
- `aligner_data_en` out 1: single-cycle qualifier for `aligner_data`.

## Operation
- Derived values, latched in LOAD:
  - off = `src_addr[2:0]`
  - L = `byte_length`
  - N_src = ceil((off+L)/8), computed in 17 bits
  - N_out = ceil(L/8)
  - base = {`src_addr[31:3]`,3'b0}
- Counters:
  - `issued`: 0..N_src
  - `outstanding`: 0..MAX_OUTSTANDING
  - `received`: 0..N_src
  - `sent`: 0..N_out
  - `hold`: 64-bit holding register
- States:
  - IDLE
  - LOAD
  - RUN
  - FLUSH
  - DONE
  - DRAIN
- Transitions:
  - IDLE → LOAD when `busif_start` is high.
  - LOAD → DONE if L==0. No reads are issued and nothing is output.
  - LOAD → RUN otherwise.
  - RUN → FLUSH when the last source qword has been received, off≠0, and N_out==N_src.
  - RUN → DONE when `sent`==N_out.
  - FLUSH → DONE after one cycle.
  - DONE → IDLE when `busif_start` is low.
  - Any state other than IDLE/DONE: if `busif_start` goes low, go to DRAIN.
  - DRAIN → IDLE when `outstanding`==0.
- Request issue:
  - `rd_req` is high in RUN while `issued`<N_src and `outstanding`<MAX_OUTSTANDING.
  - `rd_addr` = base + 8·`issued`, modulo 2^32 (address wrap is allowed).
  - On ack: `issued`++ and `outstanding`++.
  - On `rd_data_valid`: `outstanding`--.
  - Simultaneous ack and valid leave `outstanding` unchanged.
- Alignment when off==0: each received qword is output unchanged.
- Alignment when off≠0:
  - The first received qword only loads `hold`.
  - Every later received qword outputs ({rd_data,hold} >> 8·off)[63:0] and then loads `hold`.
  - FLUSH outputs `hold` >> 8·off, zero-filled.
- Tail masking: on the output where `sent`==N_out−1, bytes ≥ L[2:0] are forced to 0 when L[2:0]≠0.
- DRAIN: `rd_req`=0. Returned data is discarded and `aligner_data_en` stays 0.
- Data arriving with `rd_data_valid` in IDLE/DONE is ignored.

## Timing
- Reset values:
  - `rd_req`=0, `rd_addr`=0, `aligner_data`=0, `aligner_data_en`=0
  - state=IDLE, all counters and `hold`=0
- `busif_start` rising at edge E: LOAD during cycle E, RUN from E+1. The first `rd_req` is visible in cycle E+1.
- `rd_data_valid` at edge t → `aligner_data_en` high during cycle t+1 (registered output).
- FLUSH output appears one cycle after the output produced by the last source qword.
- When off≠0 and N_src==1, the FLUSH output appears one cycle after the `hold` load.
- `aligner_data_en` is never high two cycles after `sent` reaches N_out.
- `rd_req` drops in the cycle after the ack that makes `issued`==N_src, or that makes `outstanding`==MAX_OUTSTANDING.
- Back-to-back: a new transfer is accepted only after DONE→IDLE, i.e. after one cycle of `busif_start` low.

## Test plan
- **Aligned, 2 qwords.** `src_addr`=0x1000, L=16, zero-latency ack, data latency 2 → reads at 0x1000 and 0x1008; two outputs equal to the source qwords; `aligner_data_en` one cycle after each `rd_data_valid`.
- **Misaligned with flush.** `src_addr`=0x2003, L=13, source bytes 0x00..0x0F → output0 bytes 0x03..0x0A; FLUSH output1 = 0x000000_0F0E0D0C0B.
- **Single-read flush.** `src_addr`=0x3005, L=3 → one read at 0x3000; one output = 0x0000000000_070605 (bytes 5..7 of the source qword, upper five bytes zero).
- **Outstanding limit.** MAX_OUTSTANDING=2, L=64 aligned, data latency 10 → `outstanding` never exceeds 2; 8 reads; 8 outputs in order.
- **Abort.** Drop `busif_start` after 2 acks with 2 reads still outstanding → `rd_req` falls; state goes to DRAIN; the late `rd_data_valid` produces no `aligner_data_en`; back to IDLE once `outstanding`==0.
- **Zero length and async reset.** L=0 → no `rd_req`, no output, DONE. Separately, `rst_n` asserted mid-RUN → all outputs 0 immediately and state IDLE.

Source files
------------

// File: rtl/upstream_aligner_if.sv
// Source read bus, transfer control and aligned output stream of the upstream aligner.
// master is the aligner side; slave is the read-bus responder and transfer controller.
interface upstream_aligner_if;
    logic        busif_start;
    logic [31:0] src_addr;
    logic [15:0] byte_length;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic [63:0] aligner_data;
    logic        aligner_data_en;

    modport master (
        input  busif_start, src_addr, byte_length, rd_ack, rd_data, rd_data_valid,
        output rd_req, rd_addr, aligner_data, aligner_data_en
    );

    modport slave (
        output busif_start, src_addr, byte_length, rd_ack, rd_data, rd_data_valid,
        input  rd_req, rd_addr, aligner_data, aligner_data_en
    );
endinterface

// File: rtl/upstream_aligner.sv
// Fetches a byte-addressed source buffer as qword-aligned reads and re-packs it
// so output byte 0 is the byte at src_addr; streams ceil(len/8) qwords, no backpressure.
module upstream_aligner #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    upstream_aligner_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE, DRAIN} state_t;

    state_t      state;
    logic [2:0]  off;
    logic [2:0]  len_tail;
    logic [16:0] n_src;
    logic [16:0] n_out;
    logic [31:0] base;
    logic [16:0] issued;
    logic [16:0] received;
    logic [16:0] sent;
    logic [3:0]  outstanding;
    logic [63:0] hold;

    logic        ack;
    logic        take;
    logic        run_take;
    logic        emit;
    logic [16:0] issued_n;
    logic [16:0] received_n;
    logic [16:0] sent_n;
    logic [3:0]  outstanding_n;
    logic [16:0] n_src_w;
    logic [16:0] n_out_w;
    logic [63:0] data_p0;

    function automatic logic [63:0] align_qword(input logic [63:0] hi, input logic [63:0] lo,
                                                input logic [2:0] sh);
        logic [127:0] cat;
        cat = {hi, lo} >> {sh, 3'b000};
        return cat[63:0];
    endfunction

    // Keeps the low nb bytes; nb==0 means the whole qword is valid.
    function automatic logic [63:0] tail_mask(input logic [63:0] d, input logic [2:0] nb);
        logic [63:0] m;
        m = '1;
        if (nb != 3'd0) m = ~(64'hFFFF_FFFF_FFFF_FFFF << {nb, 3'b000});
        return d & m;
    endfunction

    assign n_src_w = (17'(bus.src_addr[2:0]) + 17'(bus.byte_length) + 17'd7) >> 3;
    assign n_out_w = (17'(bus.byte_length) + 17'd7) >> 3;
    assign ack     = bus.rd_req & bus.rd_ack;

    always_comb begin
        take          = bus.rd_data_valid && (outstanding != 4'd0);
        run_take      = (state == RUN) && take;
        // With a misaligned start the first qword only primes the holding register.
        emit          = run_take && ((off == 3'd0) || (received != 17'd0));
        issued_n      = issued + 17'(ack);
        received_n    = received + 17'(run_take);
        sent_n        = sent + 17'(emit);
        outstanding_n = outstanding;
        if (ack && !take)      outstanding_n = outstanding + 4'd1;
        else if (!ack && take) outstanding_n = outstanding - 4'd1;
        data_p0 = (off == 3'd0) ? bus.rd_data : align_qword(bus.rd_data, hold, off);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            off                 <= '0;
            len_tail            <= '0;
            n_src               <= '0;
            n_out               <= '0;
            base                <= '0;
            issued              <= '0;
            received            <= '0;
            sent                <= '0;
            outstanding         <= '0;
            hold                <= '0;
            bus.rd_req          <= 1'b0;
            bus.rd_addr         <= '0;
            bus.aligner_data    <= '0;
            bus.aligner_data_en <= 1'b0;
        end else begin
            bus.aligner_data_en <= 1'b0;
            bus.rd_req          <= 1'b0;
            issued              <= issued_n;
            outstanding         <= outstanding_n;
            case (state)
                IDLE: if (bus.busif_start) state <= LOAD;
                LOAD: begin
                    off      <= bus.src_addr[2:0];
                    len_tail <= bus.byte_length[2:0];
                    n_src    <= n_src_w;
                    n_out    <= n_out_w;
                    base     <= {bus.src_addr[31:3], 3'b000};
                    issued   <= '0;
                    received <= '0;
                    sent     <= '0;
                    hold     <= '0;
                    if (!bus.busif_start) begin
                        state <= DRAIN;
                    end else if (bus.byte_length == 16'd0) begin
                        state <= DONE;
                    end else begin
                        state       <= RUN;
                        bus.rd_req  <= 1'b1;
                        bus.rd_addr <= {bus.src_addr[31:3], 3'b000};
                    end
                end
                RUN: begin
                    if (!bus.busif_start) begin
                        state <= DRAIN;
                    end else begin
                        if (emit) begin
                            bus.aligner_data    <= tail_mask(data_p0,
                                (sent == n_out - 17'd1) ? len_tail : 3'd0);
                            bus.aligner_data_en <= 1'b1;
                        end
                        if (run_take && (off != 3'd0)) hold <= bus.rd_data;
                        received    <= received_n;
                        sent        <= sent_n;
                        bus.rd_req  <= (issued_n < n_src) &&
                                       (outstanding_n < 4'(MAX_OUTSTANDING));
                        bus.rd_addr <= base + (32'(issued_n) << 3);
                        if (sent_n == n_out)
                            state <= DONE;
                        else if ((received_n == n_src) && (off != 3'd0) && (n_out == n_src))
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!bus.busif_start) begin
                        state <= DRAIN;
                    end else begin
                        bus.aligner_data    <= tail_mask(align_qword(64'd0, hold, off), len_tail);
                        bus.aligner_data_en <= 1'b1;
                        sent                <= sent + 17'd1;
                        state               <= DONE;
                    end
                end
                DONE:  if (!bus.busif_start) state <= IDLE;
                DRAIN: if (outstanding == 4'd0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_upstream_aligner.sv
// Directed bench for upstream_aligner: aligned, misaligned, flush, outstanding limit,
// abort, zero length and asynchronous reset, against hand-computed qwords.
module tb_upstream_aligner;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic clk = 1'b0;
    logic rst_n;

    upstream_aligner_if bus ();

    upstream_aligner #(.MAX_OUTSTANDING(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int maxq  = 0;
    logic [63:0] out_q[$];
    int          out_cyc[$];
    int          vld_cyc[$];
    logic [31:0] acc_q[$];
    logic [31:0] pend_a[$];
    int          pend_t[$];
    logic [2:0]  st_now;

    assign st_now = dut.state;

    // Source memory: every byte holds the low byte of its own address.
    function automatic logic [63:0] qword_at(input logic [31:0] a);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < 8; i++) q[8*i +: 8] = a[7:0] + 8'(i);
        return q;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int i, input logic [63:0] exp);
        chk(tag, (out_q.size() > i) ? out_q[i] : 64'hx, exp);
    endtask

    task automatic chk_acc(input string tag, input int i, input logic [31:0] exp);
        chk(tag, (acc_q.size() > i) ? 64'(acc_q[i]) : 64'hx, 64'(exp));
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (st_now !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(st_now), 64'(st));
    endtask

    task automatic begin_xfer(input logic [31:0] a, input logic [15:0] l, input int latency);
        @(negedge clk);
        out_q.delete();
        out_cyc.delete();
        vld_cyc.delete();
        acc_q.delete();
        maxq            = 0;
        lat             = latency;
        bus.src_addr    = a;
        bus.byte_length = l;
        bus.busif_start = 1'b1;
    endtask

    task automatic end_xfer(input string tag);
        @(negedge clk);
        bus.busif_start = 1'b0;
        @(negedge clk);
        chk(tag, 64'(st_now), 64'(S_IDLE));
    endtask

    // Read-bus responder and output monitor, all on the falling edge.
    initial begin
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.aligner_data_en) begin
                out_q.push_back(bus.aligner_data);
                out_cyc.push_back(cyc);
            end
            if (pend_a.size() != 0 && pend_t[0] <= cyc) begin
                bus.rd_data_valid = 1'b1;
                bus.rd_data       = qword_at(pend_a.pop_front());
                void'(pend_t.pop_front());
                vld_cyc.push_back(cyc);
            end else begin
                bus.rd_data_valid = 1'b0;
            end
            if (bus.rd_req && bus.rd_ack && rst_n) begin
                acc_q.push_back(bus.rd_addr);
                pend_a.push_back(bus.rd_addr);
                pend_t.push_back(cyc + lat);
                if (pend_a.size() > maxq) maxq = pend_a.size();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n           = 1'b0;
        bus.busif_start = 1'b0;
        bus.src_addr    = '0;
        bus.byte_length = '0;
        bus.rd_ack      = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(bus.rd_req), 64'd0);
        chk("rst_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_data", bus.aligner_data, 64'd0);
        chk("rst_en", 64'(bus.aligner_data_en), 64'd0);
        chk("rst_state", 64'(st_now), 64'(S_IDLE));
        rst_n = 1'b1;

        // Aligned, two qwords, data latency 2.
        begin_xfer(32'h0000_1000, 16'd16, 2);
        @(negedge clk);
        chk("t1_load_state", 64'(st_now), 64'(S_LOAD));
        chk("t1_load_req", 64'(bus.rd_req), 64'd0);
        @(negedge clk);
        chk("t1_run_state", 64'(st_now), 64'(S_RUN));
        chk("t1_first_req", 64'(bus.rd_req), 64'd1);
        chk("t1_first_addr", 64'(bus.rd_addr), 64'h1000);
        wait_state(S_DONE, 40, "t1_done");
        end_xfer("t1_idle");
        chk("t1_nout", 64'(out_q.size()), 64'd2);
        chk_out("t1_out0", 0, 64'h0706_0504_0302_0100);
        chk_out("t1_out1", 1, 64'h0F0E_0D0C_0B0A_0908);
        chk("t1_nacc", 64'(acc_q.size()), 64'd2);
        chk_acc("t1_acc0", 0, 32'h0000_1000);
        chk_acc("t1_acc1", 1, 32'h0000_1008);
        chk("t1_en_lag0", 64'((out_cyc.size() > 0 && vld_cyc.size() > 0) ? out_cyc[0] - vld_cyc[0] : -1), 64'd1);
        chk("t1_en_lag1", 64'((out_cyc.size() > 1 && vld_cyc.size() > 1) ? out_cyc[1] - vld_cyc[1] : -1), 64'd1);

        // Misaligned with flush.
        begin_xfer(32'h0000_2003, 16'd13, 1);
        wait_state(S_DONE, 40, "t2_done");
        end_xfer("t2_idle");
        chk("t2_nout", 64'(out_q.size()), 64'd2);
        chk_out("t2_out0", 0, 64'h0A09_0807_0605_0403);
        chk_out("t2_out1", 1, 64'h0000_000F_0E0D_0C0B);
        chk_acc("t2_acc0", 0, 32'h0000_2000);
        chk_acc("t2_acc1", 1, 32'h0000_2008);
        chk("t2_flush_gap", 64'((out_cyc.size() > 1) ? out_cyc[1] - out_cyc[0] : -1), 64'd1);

        // Single read, flush only.
        begin_xfer(32'h0000_3005, 16'd3, 2);
        wait_state(S_DONE, 40, "t3_done");
        end_xfer("t3_idle");
        chk("t3_nacc", 64'(acc_q.size()), 64'd1);
        chk_acc("t3_acc0", 0, 32'h0000_3000);
        chk("t3_nout", 64'(out_q.size()), 64'd1);
        chk_out("t3_out0", 0, 64'h0000_0000_0007_0605);
        chk("t3_flush_lag", 64'((out_cyc.size() > 0 && vld_cyc.size() > 0) ? out_cyc[0] - vld_cyc[0] : -1), 64'd2);

        // Outstanding limit with long data latency.
        begin_xfer(32'h0000_4000, 16'd64, 10);
        wait_state(S_DONE, 300, "t4_done");
        end_xfer("t4_idle");
        chk("t4_maxq", 64'(maxq), 64'd2);
        chk("t4_nacc", 64'(acc_q.size()), 64'd8);
        chk_acc("t4_acc7", 7, 32'h0000_4038);
        chk("t4_nout", 64'(out_q.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk_out($sformatf("t4_out%0d", i), i, 64'h0706_0504_0302_0100 + 64'(i) * 64'h0808_0808_0808_0808);

        // Aligned with partial tail.
        begin_xfer(32'h0000_5000, 16'd10, 1);
        wait_state(S_DONE, 40, "t5_done");
        end_xfer("t5_idle");
        chk("t5_nout", 64'(out_q.size()), 64'd2);
        chk_out("t5_out0", 0, 64'h0706_0504_0302_0100);
        chk_out("t5_out1", 1, 64'h0000_0000_0000_0908);

        // Misaligned, no flush needed.
        begin_xfer(32'h0000_6006, 16'd8, 1);
        wait_state(S_DONE, 40, "t6_done");
        end_xfer("t6_idle");
        chk("t6_nacc", 64'(acc_q.size()), 64'd2);
        chk("t6_nout", 64'(out_q.size()), 64'd1);
        chk_out("t6_out0", 0, 64'h0D0C_0B0A_0908_0706);

        // Abort with two reads in flight.
        begin_xfer(32'h0000_7000, 16'd64, 20);
        n = 0;
        while (acc_q.size() < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t7_two_acks", 64'(acc_q.size()), 64'd2);
        bus.busif_start = 1'b0;
        @(negedge clk);
        chk("t7_drain_state", 64'(st_now), 64'(S_DRAIN));
        chk("t7_drain_req", 64'(bus.rd_req), 64'd0);
        wait_state(S_IDLE, 60, "t7_idle");
        chk("t7_outstanding", 64'(dut.outstanding), 64'd0);
        @(negedge clk);
        chk("t7_late_valids", 64'(vld_cyc.size()), 64'd2);
        chk("t7_no_output", 64'(out_q.size()), 64'd0);
        chk("t7_nacc", 64'(acc_q.size()), 64'd2);

        // Zero length.
        begin_xfer(32'h0000_8000, 16'd0, 1);
        @(negedge clk);
        chk("t8_load", 64'(st_now), 64'(S_LOAD));
        @(negedge clk);
        chk("t8_done", 64'(st_now), 64'(S_DONE));
        repeat (3) @(negedge clk);
        end_xfer("t8_idle");
        chk("t8_nacc", 64'(acc_q.size()), 64'd0);
        chk("t8_nout", 64'(out_q.size()), 64'd0);

        // Asynchronous reset in the middle of RUN.
        begin_xfer(32'h0000_9000, 16'd64, 3);
        n = 0;
        while (out_q.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t9_running", 64'(st_now), 64'(S_RUN));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t9_rst_req", 64'(bus.rd_req), 64'd0);
        chk("t9_rst_addr", 64'(bus.rd_addr), 64'd0);
        chk("t9_rst_data", bus.aligner_data, 64'd0);
        chk("t9_rst_en", 64'(bus.aligner_data_en), 64'd0);
        chk("t9_rst_state", 64'(st_now), 64'(S_IDLE));
        bus.busif_start = 1'b0;
        pend_a.delete();
        pend_t.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t9_after_state", 64'(st_now), 64'(S_IDLE));
        chk("t9_after_req", 64'(bus.rd_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
